// File: rtl/dram_m_wr_arb_if.sv
// dram_m_wr_arb_if: bundle between the write requesters / clear controller and the write-port scheduler
//   clr_start/clr_data  -> start a full-RAM fill with clr_data
//   clr_busy/clr_done   <- fill in progress / one-cycle pulse with the final fill write
//   wr_req_x/addr/data  -> requester x write, held until wr_ack_x
//   wr_ack_x            <- combinational accept for requester x
//   ram_en/we/addr/din  <- registered drive of the RAM write port
interface dram_m_wr_arb_if #(
   parameter int addr_bits = 6,
   parameter int data_bits = 8
);
   logic                 clr_start;
   logic [data_bits-1:0] clr_data;
   logic                 clr_busy;
   logic                 clr_done;
   logic                 wr_req_0;
   logic [addr_bits-1:0] wr_addr_0;
   logic [data_bits-1:0] wr_data_0;
   logic                 wr_ack_0;
   logic                 wr_req_1;
   logic [addr_bits-1:0] wr_addr_1;
   logic [data_bits-1:0] wr_data_1;
   logic                 wr_ack_1;
   logic                 ram_en;
   logic                 ram_we;
   logic [addr_bits-1:0] ram_addr;
   logic [data_bits-1:0] ram_din;
   modport master (
      output clr_start, clr_data, wr_req_0, wr_addr_0, wr_data_0, wr_req_1, wr_addr_1, wr_data_1,
      input  clr_busy, clr_done, wr_ack_0, wr_ack_1, ram_en, ram_we, ram_addr, ram_din
   );
   modport slave (
      input  clr_start, clr_data, wr_req_0, wr_addr_0, wr_data_0, wr_req_1, wr_addr_1, wr_data_1,
      output clr_busy, clr_done, wr_ack_0, wr_ack_1, ram_en, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/dram_m_wr_arb.sv
// dram_m_wr_arb: shares the side-info RAM write port between two requesters and a full-RAM clear sequencer
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    dram_m_wr_arb_if.slave: clear control, two request/ack write ports, RAM en/we/addr/din drive
module dram_m_wr_arb #(
   parameter int addr_bits = 6,
   parameter int data_bits = 8
) (
   input logic            clk,
   input logic            rst_n,
   dram_m_wr_arb_if.slave bus
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t               state, state_nxt;
   logic [addr_bits-1:0] clr_cnt;
   logic [data_bits-1:0] clr_val;
   logic                 rr_last;
   logic                 last_clr;
   logic                 clr_wr;
   logic                 acc;
   logic [addr_bits-1:0] w_addr;
   logic [data_bits-1:0] w_data;
   assign last_clr = clr_cnt == {addr_bits{1'b1}};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb
      state_nxt = state == IDLE ? (bus.clr_start ? CLEAR : IDLE) : (last_clr ? IDLE : CLEAR);
   // rr_last=1 lets requester 0 win a tie; a clr_start in IDLE blocks both grants that cycle
   always_comb begin
      clr_wr       = state == CLEAR;
      bus.wr_ack_0 = rst_n && state == IDLE && !bus.clr_start && bus.wr_req_0 && (!bus.wr_req_1 || rr_last);
      bus.wr_ack_1 = rst_n && state == IDLE && !bus.clr_start && bus.wr_req_1 && (!bus.wr_req_0 || !rr_last);
      acc          = clr_wr || bus.wr_ack_0 || bus.wr_ack_1;
      w_addr       = clr_wr ? clr_cnt : bus.wr_ack_1 ? bus.wr_addr_1 : bus.wr_addr_0;
      w_data       = clr_wr ? clr_val : bus.wr_ack_1 ? bus.wr_data_1 : bus.wr_data_0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         clr_cnt      <= '0;
         clr_val      <= '0;
         rr_last      <= 1'b1;
         bus.clr_busy <= 1'b0;
         bus.clr_done <= 1'b0;
         bus.ram_en   <= 1'b0;
         bus.ram_we   <= 1'b0;
         bus.ram_addr <= '0;
         bus.ram_din  <= '0;
      end else begin
         bus.clr_busy <= clr_wr;
         bus.clr_done <= clr_wr && last_clr;
         bus.ram_en   <= acc;
         bus.ram_we   <= acc;
         if (acc) begin
            bus.ram_addr <= w_addr;
            bus.ram_din  <= w_data;
         end
         if (state == IDLE && bus.clr_start) begin
            clr_val <= bus.clr_data;
            clr_cnt <= '0;
         end else if (clr_wr)
            clr_cnt <= clr_cnt + 1'b1;
         if (bus.wr_ack_0)      rr_last <= 1'b0;
         else if (bus.wr_ack_1) rr_last <= 1'b1;
      end
endmodule

// File: tb/tb_dram_m_wr_arb.sv
// tb_dram_m_wr_arb: directed stimulus, per-cycle comparison against a behavioural scheduler model, literal spot checks
module tb_dram_m_wr_arb;
   localparam int AB = 6;
   localparam int DB = 8;
   localparam int DEPTH = 1 << AB;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   dram_m_wr_arb_if #(.addr_bits(AB), .data_bits(DB)) bus ();
   dram_m_wr_arb #(.addr_bits(AB), .data_bits(DB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int vecs = 0;
   int errs = 0;
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   logic [DB-1:0] mem [DEPTH];
   always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
   // model: pending clear writes as a countdown, last winner as a plain integer
   int            m_left;
   logic [DB-1:0] m_val;
   int            m_last;
   logic          e_we, e_busy, e_done;
   logic [AB-1:0] e_addr;
   logic [DB-1:0] e_din;
   function automatic logic exp_ack(input int x);
      logic r0, r1;
      r0 = bus.wr_req_0;
      r1 = bus.wr_req_1;
      if (!rst_n || m_left > 0 || bus.clr_start) return 1'b0;
      if (r0 && r1) return (x == 0) ? (m_last == 1) : (m_last == 0);
      return (x == 0) ? r0 : r1;
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_left <= 0; m_val <= '0; m_last <= 1;
         e_we <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_addr <= '0; e_din <= '0;
      end else begin
         e_busy <= m_left > 0;
         e_done <= m_left == 1;
         e_we   <= m_left > 0 || exp_ack(0) || exp_ack(1);
         if (m_left > 0) begin
            e_addr <= AB'(DEPTH - m_left);
            e_din  <= m_val;
            m_left <= m_left - 1;
         end else if (bus.clr_start) begin
            m_left <= DEPTH;
            m_val  <= bus.clr_data;
         end else if (exp_ack(0)) begin
            e_addr <= bus.wr_addr_0; e_din <= bus.wr_data_0; m_last <= 0;
         end else if (exp_ack(1)) begin
            e_addr <= bus.wr_addr_1; e_din <= bus.wr_data_1; m_last <= 1;
         end
      end
   always @(negedge clk)
      if (!rst_n) begin
         check("rst_we", bus.ram_we, 0);
         check("rst_en", bus.ram_en, 0);
         check("rst_addr", bus.ram_addr, 0);
         check("rst_din", bus.ram_din, 0);
         check("rst_busy", bus.clr_busy, 0);
         check("rst_done", bus.clr_done, 0);
         check("rst_ack0", bus.wr_ack_0, 0);
         check("rst_ack1", bus.wr_ack_1, 0);
      end else begin
         check("ack0", bus.wr_ack_0, exp_ack(0));
         check("ack1", bus.wr_ack_1, exp_ack(1));
         check("we", bus.ram_we, e_we);
         check("en", bus.ram_en, e_we);
         if (e_we) begin
            check("addr", bus.ram_addr, e_addr);
            check("din", bus.ram_din, e_din);
         end
         check("busy", bus.clr_busy, e_busy);
         check("done", bus.clr_done, e_done);
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int order[$];
      logic g0, g1, got, found;
      int n, bad, done_cnt, done_addr, ack_in_clr, cnt;
      bus.clr_start = 0; bus.clr_data = '0;
      bus.wr_req_0 = 0; bus.wr_addr_0 = '0; bus.wr_data_0 = '0;
      bus.wr_req_1 = 0; bus.wr_addr_1 = '0; bus.wr_data_1 = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("idle_we", bus.ram_we, 0);
      end
      tick();
      bus.wr_req_0 = 1; bus.wr_addr_0 = 6'd10; bus.wr_data_0 = 8'hA0;
      bus.wr_req_1 = 1; bus.wr_addr_1 = 6'd20; bus.wr_data_1 = 8'hB1;
      for (int i = 0; i < 6 && order.size() < 2; i++) begin
         @(negedge clk);
         g0 = bus.wr_ack_0;
         g1 = bus.wr_ack_1;
         if (g0) order.push_back(0);
         if (g1) order.push_back(1);
         tick();
         if (g0) bus.wr_req_0 = 0;
         if (g1) bus.wr_req_1 = 0;
      end
      check("rr_first", order.size() > 0 ? order[0] : 9, 0);
      check("rr_second", order.size() > 1 ? order[1] : 9, 1);
      bus.wr_req_0 = 1; bus.wr_req_1 = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rr_alt", {bus.wr_ack_1, bus.wr_ack_0}, (i % 2) ? 2 : 1);
         tick();
      end
      bus.wr_req_0 = 0; bus.wr_req_1 = 0;
      tick();
      bus.wr_req_0 = 1; bus.wr_addr_0 = 6'd5; bus.wr_data_0 = 8'h3C;
      @(negedge clk);
      check("single_ack", bus.wr_ack_0, 1);
      tick();
      bus.wr_req_0 = 0;
      @(negedge clk);
      check("single_we", bus.ram_we, 1);
      check("single_addr", bus.ram_addr, 5);
      check("single_din", bus.ram_din, 8'h3C);
      tick();
      @(negedge clk);
      check("single_mem", mem[5], 8'h3C);
      check("single_we_off", bus.ram_we, 0);
      tick();
      bus.clr_start = 1; bus.clr_data = 8'hFF;
      bus.wr_req_1 = 1; bus.wr_addr_1 = 6'd7; bus.wr_data_1 = 8'h55;
      @(negedge clk);
      check("clr_start_ack1", bus.wr_ack_1, 0);
      tick();
      bus.clr_start = 0;
      n = 0; bad = 0; done_cnt = 0; done_addr = -1; ack_in_clr = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus.ram_we) begin
            if (bus.ram_addr !== AB'(n) || bus.ram_din !== 8'hFF) bad++;
            n++;
         end
         if (bus.clr_done) begin
            done_cnt++;
            done_addr = int'(bus.ram_addr);
         end
         if (bus.wr_ack_1) begin
            if (n < DEPTH) ack_in_clr++;
            got = 1;
         end
         tick();
      end
      bus.wr_req_1 = 0;
      check("clr_writes", n, DEPTH);
      check("clr_seq_bad", bad, 0);
      check("clr_done_cnt", done_cnt, 1);
      check("clr_done_addr", done_addr, 63);
      check("ack1_in_clear", ack_in_clr, 0);
      check("ack1_after", got, 1);
      @(negedge clk);
      check("post_we", bus.ram_we, 1);
      check("post_addr", bus.ram_addr, 7);
      check("post_din", bus.ram_din, 8'h55);
      tick();
      @(negedge clk);
      check("post_mem7", mem[7], 8'h55);
      cnt = 0;
      for (int a = 0; a < DEPTH; a++) if (a != 7 && mem[a] !== 8'hFF) cnt++;
      check("mem_ff", cnt, 0);
      tick();
      bus.clr_start = 1; bus.clr_data = 8'h11;
      tick();
      bus.clr_start = 0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.ram_we && bus.ram_addr == 6'd20) found = 1;
         else tick();
      end
      check("found_write20", found, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.clr_busy, 0);
      check("midrst_we", bus.ram_we, 0);
      check("midrst_done", bus.clr_done, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("after_rst_we", bus.ram_we, 0);
      tick();
      bus.clr_start = 1; bus.clr_data = 8'h22;
      tick();
      bus.clr_start = 0;
      n = 0; done_cnt = 0; got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus.ram_we) n++;
         if (bus.clr_done) begin
            done_cnt++;
            got = 1;
         end
         tick();
      end
      check("reclr_writes", n, DEPTH);
      check("reclr_done", done_cnt, 1);
      @(negedge clk);
      check("reclr_mem0", mem[0], 8'h22);
      check("reclr_mem63", mem[63], 8'h22);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
